// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin arbiter in front of a shared combinational ALU
// Optional feature macro: ALU_ARB_FIXED_PRIO_EN (defined = fixed priority, port 0 always wins contention)

module alu_arbiter #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4,
  parameter int FLAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,

  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [FLAG_W-1:0] alu_flags,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic [FLAG_W-1:0] rsp_flags
);

  // IDLE: waiting for a request; ISSUE: ALU evaluating held operands; RESP: response on offer
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [OP_W-1:0]     r_alu_op;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic                r_rsp_id;
  logic [DATA_W-1:0]   r_rsp_result;
  logic [FLAG_W-1:0]   r_rsp_flags;

  logic                w_any_valid;
  logic                w_grant_id;
  logic                w_accept;

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Port that won the most recent accept; reset to 1 so port 0 wins the first contention
  logic                r_last_grant;
`endif

  assign w_any_valid = req0_valid | req1_valid;

  // Accept only from IDLE and never while reset is asserted, so readies stay low in reset
  assign w_accept = (r_state == S_IDLE) && !rst && w_any_valid;

  // Grant selection: a lone requester always wins; contention resolved by policy
  always_comb begin
    w_grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      w_grant_id = 1'b0;
`else
      w_grant_id = ~r_last_grant;
`endif
    end else if (req1_valid) begin
      w_grant_id = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_next_state = S_ISSUE;
      S_ISSUE:                w_next_state = S_RESP;
      S_RESP:  if (rsp_ready) w_next_state = S_IDLE;
      default:                w_next_state = S_IDLE;
    endcase
  end

  // Handshake outputs: at most one ready, and only alongside its own valid
  always_comb begin
    req0_ready = w_accept && !w_grant_id;
    req1_ready = w_accept &&  w_grant_id;
    rsp_valid  = (r_state == S_RESP);
  end

  // Operand capture on accept and result capture in ISSUE; everything else holds
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_op     <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
    end else begin
      if (w_accept) begin
        r_rsp_id <= w_grant_id;
        if (w_grant_id) begin
          r_alu_op <= req1_op;
          r_alu_a  <= req1_a;
          r_alu_b  <= req1_b;
        end else begin
          r_alu_op <= req0_op;
          r_alu_a  <= req0_a;
          r_alu_b  <= req0_b;
        end
      end
      if (r_state == S_ISSUE) begin
        r_rsp_result <= alu_result;
        r_rsp_flags  <= alu_flags;
      end
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Round-robin pointer follows every accepted request
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= w_grant_id;
    end
  end
`endif

  assign alu_op     = r_alu_op;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a behavioural ALU model

module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_flags;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_result;
  logic [3:0] rsp_flags;
  logic [7:0] perturb;
  logic [7:0] w_model_res;

  typedef struct {
    logic       id;
    logic [7:0] res;
    logic [3:0] flg;
  } exp_t;

  exp_t sb[$];
  logic grant_log[$];
  int   p1_acc[$];
  int   cyc = 0;
  int   rsp_count = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic       hold_prev = 1'b0;
  logic       prev_id;
  logic [7:0] prev_res;
  logic [3:0] prev_flg;

  alu_arbiter #(.DATA_W(8), .OP_W(4), .FLAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: returns {Z,N,C,V,result}
  function automatic logic [11:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      OP_SUB: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
      OP_AND: r = a & b;
      OP_XOR: r = a ^ b;
      default: r = '0;
    endcase
    return {(r == 8'h00), r[7], c, v, r};
  endfunction

  function automatic exp_t mk(input logic id, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.id = id;
    {e.flg, e.res} = alu_f(op, a, b);
    return e;
  endfunction

  always_comb begin
    {alu_flags, w_model_res} = alu_f(alu_op, alu_a, alu_b);
    alu_result = w_model_res ^ perturb;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    check(tag, sb.size(), 0);
  endtask

  // Monitor: push expectations on accept, pop and compare on response
  always @(negedge clk) begin
    if (!rst) begin
      check("ready0_without_valid", req0_ready & ~req0_valid, 0);
      check("ready1_without_valid", req1_ready & ~req1_valid, 0);
      check("ready_both", req0_ready & req1_ready, 0);
      if (req0_valid && req0_ready) begin
        sb.push_back(mk(1'b0, req0_op, req0_a, req0_b));
        grant_log.push_back(1'b0);
      end
      if (req1_valid && req1_ready) begin
        sb.push_back(mk(1'b1, req1_op, req1_a, req1_b));
        grant_log.push_back(1'b1);
        p1_acc.push_back(cyc);
      end
      if (hold_prev) begin
        check("hold_result", rsp_result, prev_res);
        check("hold_flags", rsp_flags, prev_flg);
        check("hold_id", rsp_id, prev_id);
        check("hold_valid", rsp_valid, 1);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          check("rsp_id", rsp_id, sb[0].id);
          check("rsp_result", rsp_result, sb[0].res);
          check("rsp_flags", rsp_flags, sb[0].flg);
          void'(sb.pop_front());
        end
        rsp_count <= rsp_count + 1;
      end
      hold_prev <= rsp_valid && !rsp_ready;
      prev_id   <= rsp_id;
      prev_res  <= rsp_result;
      prev_flg  <= rsp_flags;
    end else begin
      hold_prev <= 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_g [4];
    int   base;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    perturb = 8'h00;
    rst = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 8'h7F; req0_b = 8'h01;
    req1_valid = 1'b1; req1_op = OP_SUB; req1_a = 8'h10; req1_b = 8'h03;

    // Reset held 3 cycles with both valids high
    repeat (3) begin
      @(negedge clk);
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_alu_a", alu_a, 0);
    end
    @(posedge clk); #1 rst = 1'b0;

    // First accept right after reset goes to port 0; single ADD 7F+01
    @(negedge clk);
    check("first_grant_p0", req0_ready, 1);
    check("first_grant_p1", req1_ready, 0);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    check("single_n1_no_rsp", rsp_valid, 0);
    check("single_n1_alu_a", alu_a, 8'h7F);
    @(negedge clk);
    check("single_n2_valid", rsp_valid, 1);
    check("single_id", rsp_id, 0);
    check("single_result", rsp_result, 8'h80);
    check("single_flags_nv", rsp_flags, 4'b0101);
    @(negedge clk);
    check("p1_accept_n3", req1_ready, 1);
    @(posedge clk); #1 req1_valid = 1'b0;
    drain("drain_single");

    // Contention: both valid for 4 ops
    @(posedge clk); #1;
    grant_log.delete();
    req0_valid = 1'b1; req0_op = OP_XOR; req0_a = 8'h55; req0_b = 8'hAA;
    req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 8'hFF; req1_b = 8'h01;
    for (int i = 0; i < 60 && grant_log.size() < 4; i++) @(negedge clk);
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    check("contention_count", grant_log.size(), 4);
    if (grant_log.size() == 4)
      for (int i = 0; i < 4; i++) check($sformatf("contention_grant%0d", i), grant_log[i], exp_g[i]);
    drain("drain_contention");

    // Backpressure: response held 5 cycles while the ALU output moves
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = OP_AND; req0_a = 8'hF0; req0_b = 8'h3C;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (req0_ready) break; end
    check("bp_accept", req0_ready, 1);
    @(posedge clk); #1 req0_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (rsp_valid) break; end
    check("bp_rsp_valid", rsp_valid, 1);
    base = rsp_count;
    repeat (5) begin
      @(posedge clk); #1;
      perturb = 8'hFF;
      req1_valid = 1'b1; req1_op = OP_SUB; req1_a = 8'h05; req1_b = 8'h09;
      @(negedge clk);
      check("bp_result_stable", rsp_result, 8'h30);
      check("bp_valid_held", rsp_valid, 1);
      check("bp_no_ready0", req0_ready, 0);
      check("bp_no_ready1", req1_ready, 0);
    end
    check("bp_alu_a_hold", alu_a, 8'hF0);
    check("bp_no_rsp_yet", rsp_count, base);
    @(posedge clk); #1 rsp_ready = 1'b1; perturb = 8'h00;
    @(negedge clk);
    check("bp_resp_cycle_no_ready1", req1_ready, 0);
    check("bp_resp_cycle_valid", rsp_valid, 1);
    @(negedge clk);
    check("bp_one_rsp", rsp_count, base + 1);
    check("bp_next_idle_ready1", req1_ready, 1);
    @(posedge clk); #1 req1_valid = 1'b0;
    drain("drain_bp");

    // Reset during ISSUE drops the op and restores port-0 priority
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 8'h01; req0_b = 8'h01;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (req0_ready) break; end
    check("midrst_accept", req0_ready, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    void'(sb.pop_back());
    req0_op = OP_XOR; req0_a = 8'h3C; req0_b = 8'h3C;
    req1_valid = 1'b1; req1_op = OP_AND; req1_a = 8'hA5; req1_b = 8'h0F;
    @(negedge clk);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_ready0", req0_ready, 0);
    check("midrst_ready1", req1_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_idle_grant0", req0_ready, 1);
    check("midrst_idle_grant1", req1_ready, 0);
    check("midrst_no_rsp", rsp_valid, 0);

    // Throughput: back-to-back port 1 ops
    @(posedge clk); #1;
    req0_valid = 1'b0;
    p1_acc.delete();
    for (int i = 0; i < 40 && p1_acc.size() < 4; i++) @(negedge clk);
    @(posedge clk); #1 req1_valid = 1'b0;
    check("tput_count", p1_acc.size(), 4);
    if (p1_acc.size() == 4)
      for (int i = 1; i < 4; i++) check($sformatf("tput_gap%0d", i), p1_acc[i] - p1_acc[i-1], 3);
    drain("drain_tput");
    @(negedge clk);
    check("total_responses", rsp_count, 13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
